// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and constants for the 3x3 convolution sequencer
package conv_pkg;
    typedef enum logic [2:0] {
        IDLE,
        FEED,
        DRAIN,
        READ_ADDR,
        READ_WAIT,
        READ_VALID,
        DONE
    } state_t;
    localparam logic [4:0] MUX_ZERO_SEL = 5'd25;
    localparam logic [4:0] FILTER_BASE  = 5'd16;
    localparam logic [3:0] N_TAPS       = 4'd9;
    localparam logic [2:0] N_RESULTS    = 3'd4;
endpackage

// File: rtl/conv3_tap_addr.sv
// conv3_tap_addr: maps tap t (0..8) to the four operand-mux selects
//   tap            : tap index, (r,c) = (t/3, t%3)
//   input_side     : 4r+c
//   input_ceiling  : 4r+c+1
//   filter_side    : 16+t
//   filter_ceiling : 16+t
module conv3_tap_addr
    import conv_pkg::*;
(
    input  logic [3:0] tap,
    output logic [4:0] input_side,
    output logic [4:0] input_ceiling,
    output logic [4:0] filter_side,
    output logic [4:0] filter_ceiling
);
    logic [4:0] row;
    // 4r+c = (3r+c)+r = t+r, so only the row is needed
    assign row            = (tap >= 4'd6) ? 5'd2 : (tap >= 4'd3) ? 5'd1 : 5'd0;
    assign input_side     = {1'b0, tap} + row;
    assign input_ceiling  = input_side + 5'd1;
    assign filter_side    = FILTER_BASE + {1'b0, tap};
    assign filter_ceiling = filter_side;
endmodule

// File: rtl/conv3x3_sequencer.sv
// conv3x3_sequencer: sequences one 3x3 convolution pass and streams back the four results
//   clk, rst (async, active-low), start
//   input_side/input_ceiling/filter_side/filter_ceiling_array_addr_out_3by3 : operand mux selects
//   sys_3by3_en : systolic array enable
//   buffer_read_addr_out_3by3 / convolution_3by3_in : result buffer read port
//   result_data, out_valid, out_ready, result_idx : result stream
//   busy, done, start_err
//   Optional: define CONV3_SEQ_START_ERR_EN to flag start while busy (sticky start_err).
module conv3x3_sequencer
    import conv_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [4:0] input_side_array_addr_out_3by3,
    output logic [4:0] input_ceiling_array_addr_out_3by3,
    output logic [4:0] filter_side_array_addr_out_3by3,
    output logic [4:0] filter_ceiling_array_addr_out_3by3,
    output logic       sys_3by3_en,
    output logic [1:0] buffer_read_addr_out_3by3,
    input  logic [7:0] convolution_3by3_in,
    output logic [7:0] result_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] result_idx,
    output logic       busy,
    output logic       done,
    output logic       start_err
);
    state_t     state, state_nx;
    logic [3:0] tap, tap_nx, cnt, cnt_nx;
    logic [1:0] idx, idx_nx;
    logic [4:0] map_is, map_ic, map_fs, map_fc;
    logic [4:0] is_d, ic_d, fs_d, fc_d;
    logic [1:0] addr_d;
    logic       feed_d, read_d, en_d;

    conv3_tap_addr u_tap (
        .tap            (tap_nx),
        .input_side     (map_is),
        .input_ceiling  (map_ic),
        .filter_side    (map_fs),
        .filter_ceiling (map_fc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                              <= IDLE;
            tap                                <= '0;
            cnt                                <= '0;
            idx                                <= '0;
            input_side_array_addr_out_3by3     <= MUX_ZERO_SEL;
            input_ceiling_array_addr_out_3by3  <= MUX_ZERO_SEL;
            filter_side_array_addr_out_3by3    <= MUX_ZERO_SEL;
            filter_ceiling_array_addr_out_3by3 <= MUX_ZERO_SEL;
            sys_3by3_en                        <= 1'b0;
            buffer_read_addr_out_3by3          <= '0;
            result_idx                         <= '0;
            result_data                        <= '0;
            out_valid                          <= 1'b0;
            busy                               <= 1'b0;
            done                               <= 1'b0;
        end else begin
            state                              <= state_nx;
            tap                                <= tap_nx;
            cnt                                <= cnt_nx;
            idx                                <= idx_nx;
            input_side_array_addr_out_3by3     <= is_d;
            input_ceiling_array_addr_out_3by3  <= ic_d;
            filter_side_array_addr_out_3by3    <= fs_d;
            filter_ceiling_array_addr_out_3by3 <= fc_d;
            sys_3by3_en                        <= en_d;
            buffer_read_addr_out_3by3          <= addr_d;
            result_idx                         <= addr_d;
            out_valid                          <= state_nx == READ_VALID;
            busy                               <= state_nx != IDLE;
            done                               <= state_nx == DONE;
            // buffer output is valid during READ_WAIT, latch it at the end of that cycle
            if (state == READ_WAIT)
                result_data <= convolution_3by3_in;
        end
    end

    always_comb begin
        state_nx = state;
        tap_nx   = tap;
        cnt_nx   = cnt;
        idx_nx   = idx;
        case (state)
            IDLE: if (start) begin
                state_nx = FEED;
                tap_nx   = '0;
            end
            FEED: begin
                tap_nx = tap + 4'd1;
                if (tap == N_TAPS - 4'd1) begin
                    state_nx = DRAIN;
                    cnt_nx   = '0;
                end
            end
            DRAIN: begin
                cnt_nx = cnt + 4'd1;
                if (cnt == 4'(DRAIN_CYCLES - 1)) begin
                    state_nx = READ_ADDR;
                    idx_nx   = '0;
                end
            end
            READ_ADDR: state_nx = READ_WAIT;
            READ_WAIT: state_nx = READ_VALID;
            READ_VALID: if (out_ready) begin
                state_nx = (idx == 2'(N_RESULTS - 3'd1)) ? DONE : READ_ADDR;
                idx_nx   = idx + 2'd1;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // outputs are decoded from the next state so the registers line up with the state they describe
    always_comb begin
        feed_d = state_nx == FEED;
        read_d = state_nx inside {READ_ADDR, READ_WAIT, READ_VALID};
        en_d   = feed_d || state_nx == DRAIN;
        is_d   = feed_d ? map_is : MUX_ZERO_SEL;
        ic_d   = feed_d ? map_ic : MUX_ZERO_SEL;
        fs_d   = feed_d ? map_fs : MUX_ZERO_SEL;
        fc_d   = feed_d ? map_fc : MUX_ZERO_SEL;
        addr_d = read_d ? idx_nx : 2'd0;
    end

`ifdef CONV3_SEQ_START_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            start_err <= 1'b0;
        else if (start && busy)
            start_err <= 1'b1;
    end
`else
    assign start_err = 1'b0;
`endif
endmodule

// File: tb/tb_conv3x3_sequencer.sv
// tb_conv3x3_sequencer: randomized self-checking bench against a per-cycle trace model
module tb_conv3x3_sequencer;
    localparam int DRAIN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       out_ready = 1'b0;
    logic [4:0] isel, icsel, fssel, fcsel;
    logic       en, valid, busy, done, err;
    logic [1:0] addr, ridx;
    logic [7:0] conv_in, rdata;
    logic [7:0] buf_mem [4];
    int         stall_cfg [4];
    int         vecs = 0;
    int         errs = 0;
    logic       err_exp = 1'b0;

    typedef struct {
        logic [4:0] in_side, in_ceil, f_side, f_ceil;
        logic       en, valid, busy, done, rd, rdy;
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;
    exp_t q[$];

    localparam logic [40:0] RESET_V = {5'd25, 5'd25, 5'd25, 5'd25, 4'b0, 2'b0, 2'b0, 8'h00, 1'b0};

    assign conv_in = buf_mem[addr];

    conv3x3_sequencer #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk                                (clk),
        .rst                                (rst),
        .start                              (start),
        .input_side_array_addr_out_3by3     (isel),
        .input_ceiling_array_addr_out_3by3  (icsel),
        .filter_side_array_addr_out_3by3    (fssel),
        .filter_ceiling_array_addr_out_3by3 (fcsel),
        .sys_3by3_en                        (en),
        .buffer_read_addr_out_3by3          (addr),
        .convolution_3by3_in                (conv_in),
        .result_data                        (rdata),
        .out_valid                          (valid),
        .out_ready                          (out_ready),
        .result_idx                         (ridx),
        .busy                               (busy),
        .done                               (done),
        .start_err                          (err)
    );

    always #5 clk = ~clk;

    function automatic exp_t quiet();
        exp_t e;
        e.in_side = 5'd25; e.in_ceil = 5'd25; e.f_side = 5'd25; e.f_ceil = 5'd25;
        e.en = 1'b0; e.valid = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.rd = 1'b0;
        e.rdy = 1'($urandom_range(0, 1));
        e.idx = 2'd0; e.data = 8'h00;
        return e;
    endfunction

    // expected outputs for every cycle c1.. of one pass, built from the timing rules
    task automatic build();
        exp_t e;
        q.delete();
        for (int t = 0; t < 9; t++) begin
            e = quiet();
            e.in_side = 5'(4 * (t / 3) + t % 3);
            e.in_ceil = e.in_side + 5'd1;
            e.f_side  = 5'(16 + t);
            e.f_ceil  = e.f_side;
            e.en = 1'b1; e.busy = 1'b1;
            q.push_back(e);
        end
        for (int d = 0; d < DRAIN; d++) begin
            e = quiet(); e.en = 1'b1; e.busy = 1'b1;
            q.push_back(e);
        end
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < stall_cfg[i] + 3; k++) begin
                e = quiet(); e.busy = 1'b1; e.rd = 1'b1; e.idx = 2'(i);
                if (k >= 2) begin
                    e.valid = 1'b1;
                    e.data  = buf_mem[i];
                    e.rdy   = (k == stall_cfg[i] + 2);
                end
                q.push_back(e);
            end
        end
        e = quiet(); e.busy = 1'b1; e.done = 1'b1;
        q.push_back(e);
        q.push_back(quiet());
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if ({isel, icsel, fssel, fcsel, en, valid, busy, done, addr, ridx, rdata, err} !== RESET_V) begin
            errs++;
            $display("FAIL reset_held got=%h exp=%h", {isel, icsel, fssel, fcsel, en, valid, busy, done, addr, ridx, rdata, err}, RESET_V);
        end
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if ({isel, icsel, fssel, fcsel, en, valid, busy, done, addr, ridx, rdata, err} !== RESET_V) begin
            errs++;
            $display("FAIL reset_released got=%h exp=%h", {isel, icsel, fssel, fcsel, en, valid, busy, done, addr, ridx, rdata, err}, RESET_V);
        end
    endtask

    // one full pass from a start pulse; restart_k re-pulses start in that cycle (0 = never)
    task automatic test_pass(input string tag, input int restart_k);
        build();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        foreach (q[k]) begin
            out_ready = q[k].rdy;
            start     = (k + 1 == restart_k);
            @(negedge clk);
            vecs++;
            if ({isel, icsel, fssel, fcsel, en, valid, busy, done} !==
                {q[k].in_side, q[k].in_ceil, q[k].f_side, q[k].f_ceil, q[k].en, q[k].valid, q[k].busy, q[k].done}) begin
                errs++;
                $display("FAIL %s c%0d sel/en/valid/busy/done got=%0d/%0d/%0d/%0d/%b%b%b%b exp=%0d/%0d/%0d/%0d/%b%b%b%b",
                         tag, k + 1, isel, icsel, fssel, fcsel, en, valid, busy, done,
                         q[k].in_side, q[k].in_ceil, q[k].f_side, q[k].f_ceil, q[k].en, q[k].valid, q[k].busy, q[k].done);
            end
            vecs++;
            if (err !== err_exp) begin
                errs++;
                $display("FAIL %s c%0d start_err got=%b exp=%b", tag, k + 1, err, err_exp);
            end
            if (q[k].rd) begin
                vecs++;
                if (addr !== q[k].idx) begin
                    errs++;
                    $display("FAIL %s c%0d read_addr got=%0d exp=%0d", tag, k + 1, addr, q[k].idx);
                end
            end
            if (q[k].valid) begin
                vecs++;
                if ({ridx, rdata} !== {q[k].idx, q[k].data}) begin
                    errs++;
                    $display("FAIL %s c%0d idx/data got=%0d/%h exp=%0d/%h", tag, k + 1, ridx, rdata, q[k].idx, q[k].data);
                end
            end
            @(posedge clk);
`ifdef CONV3_SEQ_START_ERR_EN
            if (start && q[k].busy) err_exp = 1'b1;
`endif
            #1 start = 1'b0;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 4; i++) stall_cfg[i] = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        vecs++;
        if ({en, busy} !== 2'b11) begin
            errs++;
            $display("FAIL mid_reset_drain en/busy got=%b%b exp=11", en, busy);
        end
        rst = 1'b0;
        #1;
        vecs++;
        if ({isel, icsel, fssel, fcsel, en, valid, busy, done, addr, ridx, rdata, err} !== RESET_V) begin
            errs++;
            $display("FAIL mid_reset_async got=%h exp=%h", {isel, icsel, fssel, fcsel, en, valid, busy, done, addr, ridx, rdata, err}, RESET_V);
        end
        err_exp = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        vecs++;
        if ({isel, icsel, fssel, fcsel, en, valid, busy, done, addr, ridx, rdata, err} !== RESET_V) begin
            errs++;
            $display("FAIL mid_reset_hold got=%h exp=%h", {isel, icsel, fssel, fcsel, en, valid, busy, done, addr, ridx, rdata, err}, RESET_V);
        end
        test_pass("after_reset", 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            buf_mem[i]   = 8'(8'h11 * (i + 1));
            stall_cfg[i] = 0;
        end
        test_reset();
        test_pass("basic", 0);
        stall_cfg[1] = 5;
        test_pass("backpressure", 0);
        stall_cfg[1] = 0;
        test_pass("restart_c5", 5);
        test_mid_reset();
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 4; i++) begin
                buf_mem[i]   = 8'($urandom);
                stall_cfg[i] = $urandom_range(0, 3);
            end
            test_pass("random", 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
